// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: state encoding and default sizing shared by the LED control blocks.
package led_ctrl_pkg;
    localparam int DEF_NB_MUX_ROWS = 4;
    localparam int DEF_ON_WIDTH    = 16;
    localparam int DEF_DEAD_CYCLES = 8;
    typedef enum logic [1:0] {IDLE, LATCH, DEAD, ON} row_sched_state_t;
endpackage

// File: rtl/row_mux_scheduler_if.sv
// row_mux_scheduler_if: control, handshake and row pins between synchronizer/HPS and the scheduler.
interface row_mux_scheduler_if
    import led_ctrl_pkg::*;
#(
    parameter int NB_MUX_ROWS = DEF_NB_MUX_ROWS,
    parameter int ON_WIDTH    = DEF_ON_WIDTH
);
    logic                           enable;
    logic                           slice_start;
    logic [ON_WIDTH-1:0]            on_cycles;
    logic                           hps_override;
    logic [NB_MUX_ROWS-1:0]         hps_row_en;
    logic                           lat_ack;
    logic                           clear_overrun;
    logic [NB_MUX_ROWS-1:0]         row_en;
    logic [$clog2(NB_MUX_ROWS)-1:0] row_idx;
    logic                           lat_req;
    logic                           busy;
    logic                           slice_done;
    logic                           overrun;
    modport master (
        output enable, slice_start, on_cycles, hps_override, hps_row_en, lat_ack, clear_overrun,
        input  row_en, row_idx, lat_req, busy, slice_done, overrun
    );
    modport slave (
        input  enable, slice_start, on_cycles, hps_override, hps_row_en, lat_ack, clear_overrun,
        output row_en, row_idx, lat_req, busy, slice_done, overrun
    );
endinterface

// File: rtl/cycle_timer.sv
// cycle_timer: loadable down-counter; last is high in the final cycle of a loaded count.
module cycle_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             last
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = load ? value : (cnt_q != '0 ? cnt_q - WIDTH'(1) : '0);
        last  = cnt_q == WIDTH'(1);
    end
    always_ff @(posedge clk or posedge rst_in)
        if (rst_in) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/row_mux_scheduler.sv
// row_mux_scheduler: per-slice row sequencer (latch request, blanking, on-time) with HPS override.
module row_mux_scheduler
    import led_ctrl_pkg::*;
#(
    parameter int NB_MUX_ROWS = DEF_NB_MUX_ROWS,
    parameter int ON_WIDTH    = DEF_ON_WIDTH,
    parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
    input logic                clk,
    input logic                rst_in,
    row_mux_scheduler_if.slave bus
);
    localparam int IDX_W = $clog2(NB_MUX_ROWS);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(NB_MUX_ROWS - 1);
    row_sched_state_t       state_q, state_d;
    logic [IDX_W-1:0]       row_idx_q, row_idx_d;
    logic [ON_WIDTH-1:0]    on_q, on_d, t_val;
    logic [NB_MUX_ROWS-1:0] row_en_q, row_en_d;
    logic                   slice_done_q, slice_done_d, overrun_q, overrun_d;
    logic                   t_load, t_last, end_row, abort, busy, last_row;
    cycle_timer #(.WIDTH(ON_WIDTH)) u_timer (
        .clk    (clk),
        .rst_in (rst_in),
        .load   (t_load),
        .value  (t_val),
        .last   (t_last)
    );
    assign busy     = state_q != IDLE;
    assign last_row = row_idx_q == LAST_ROW;
    always_comb begin
        state_d      = state_q;
        row_idx_d    = row_idx_q;
        on_d         = on_q;
        t_load       = 1'b0;
        t_val        = ON_WIDTH'(DEAD_CYCLES);
        end_row      = 1'b0;
        slice_done_d = 1'b0;
        abort        = !bus.enable || bus.hps_override;
        unique case (state_q)
            IDLE:
                if (bus.slice_start && !abort) begin
                    state_d   = LATCH;
                    on_d      = bus.on_cycles;
                    row_idx_d = '0;
                end
            LATCH:
                if (bus.lat_ack) begin
                    state_d = DEAD;
                    t_load  = 1'b1;
                end
            DEAD:
                if (t_last) begin
                    if (on_q == '0) end_row = 1'b1;
                    else begin
                        state_d = ON;
                        t_load  = 1'b1;
                        t_val   = on_q;
                    end
                end
            ON:
                end_row = t_last;
        endcase
        if (end_row) begin
            state_d      = last_row ? IDLE : LATCH;
            row_idx_d    = last_row ? '0 : row_idx_q + 1'b1;
            slice_done_d = last_row;
        end
        if (abort) begin
            state_d      = IDLE;
            row_idx_d    = '0;
            slice_done_d = 1'b0;
        end
        // row_en is computed from next state so the pins change on the same edge as the FSM
        row_en_d  = bus.hps_override ? bus.hps_row_en
                  : (state_d == ON ? NB_MUX_ROWS'(1) << row_idx_d : '0);
        overrun_d = (bus.slice_start && busy && !bus.hps_override) || (overrun_q && !bus.clear_overrun);
    end
    always_ff @(posedge clk or posedge rst_in)
        if (rst_in) begin
            state_q      <= IDLE;
            row_idx_q    <= '0;
            on_q         <= '0;
            row_en_q     <= '0;
            slice_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_idx_q    <= row_idx_d;
            on_q         <= on_d;
            row_en_q     <= row_en_d;
            slice_done_q <= slice_done_d;
            overrun_q    <= overrun_d;
        end
    assign bus.row_en     = row_en_q;
    assign bus.row_idx    = row_idx_q;
    assign bus.lat_req    = state_q == LATCH;
    assign bus.busy       = busy;
    assign bus.slice_done = slice_done_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_row_mux_scheduler.sv
// tb_row_mux_scheduler: table-driven slices with a cycle-trace scoreboard plus overrun/override/reset sequences.
module tb_row_mux_scheduler;
    import led_ctrl_pkg::*;
    localparam int N = 4;
    localparam int W = 16;
    localparam int D = 8;
    typedef struct {
        logic [W-1:0] on;
        int           drow;
        int           dly;
        int           exp_done;
    } vec_t;
    typedef struct {
        logic       ack;
        logic [8:0] exp;
    } trec_t;
    logic clk = 1'b0;
    logic rst_in = 1'b1;
    int total = 0;
    int bad = 0;
    trec_t q[$];
    vec_t vt[5];
    always #5 clk = ~clk;
    row_mux_scheduler_if #(.NB_MUX_ROWS(N), .ON_WIDTH(W)) bus ();
    row_mux_scheduler #(.NB_MUX_ROWS(N), .ON_WIDTH(W), .DEAD_CYCLES(D)) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .bus    (bus)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [8:0] obs();
        return {bus.row_en, bus.row_idx, bus.lat_req, bus.busy, bus.slice_done};
    endfunction
    // expected per-cycle outputs from cycle 1 onward, written from the slice timing rules
    task automatic push_slice(input logic [W-1:0] on, input int drow, input int dly);
        for (int r = 0; r < N; r++) begin
            int extra = (r == drow) ? dly : 0;
            for (int i = 0; i <= extra; i++) q.push_back('{ack: (i == extra), exp: {4'b0, 2'(r), 3'b110}});
            for (int i = 0; i < D; i++) q.push_back('{ack: 1'b1, exp: {4'b0, 2'(r), 3'b010}});
            for (int i = 0; i < int'(on); i++) q.push_back('{ack: 1'b1, exp: {4'(1 << r), 2'(r), 3'b010}});
        end
        q.push_back('{ack: 1'b1, exp: {4'b0, 2'b0, 3'b001}});
    endtask
    task automatic run_slice(input int idx, input vec_t v);
        int cyc;
        int done_at;
        trec_t rec;
        push_slice(v.on, v.drow, v.dly);
        bus.on_cycles = v.on;
        bus.slice_start = 1'b1;
        step();
        bus.slice_start = 1'b0;
        bus.on_cycles = 16'h0005;
        cyc = 1;
        done_at = -1;
        while (q.size() > 0) begin
            rec = q.pop_front();
            bus.lat_ack = rec.ack;
            check($sformatf("trace v%0d c%0d", idx, cyc), 32'(obs()), 32'(rec.exp));
            if (bus.slice_done && done_at < 0) done_at = cyc;
            step();
            cyc++;
        end
        check($sformatf("done_cycle v%0d", idx), done_at, v.exp_done);
    endtask
    initial begin
        int i;
        logic seen;
        vt[0] = '{on: 16'd10, drow: -1, dly: 0, exp_done: 77};
        vt[1] = '{on: 16'd10, drow: 2,  dly: 4, exp_done: 81};
        vt[2] = '{on: 16'd0,  drow: -1, dly: 0, exp_done: 37};
        vt[3] = '{on: 16'd1,  drow: -1, dly: 0, exp_done: 41};
        vt[4] = '{on: 16'd3,  drow: 0,  dly: 2, exp_done: 51};
        bus.enable = 1'b1;
        bus.slice_start = 1'b0;
        bus.on_cycles = '0;
        bus.hps_override = 1'b0;
        bus.hps_row_en = '0;
        bus.lat_ack = 1'b0;
        bus.clear_overrun = 1'b0;
        repeat (2) step();
        check("reset_outs", {obs(), bus.overrun}, 0);
        rst_in = 1'b0;
        step();
        check("idle_outs", {obs(), bus.overrun}, 0);
        for (int k = 0; k < 5; k++) run_slice(k, vt[k]);
        bus.lat_ack = 1'b1;
        // overrun: second start mid-slice is flagged and ignored
        bus.on_cycles = 16'd10;
        bus.slice_start = 1'b1;
        step();
        bus.slice_start = 1'b0;
        repeat (4) step();
        bus.slice_start = 1'b1;
        step();
        bus.slice_start = 1'b0;
        check("overrun_set", bus.overrun, 1);
        repeat (6) step();
        check("no_restart_row_en", bus.row_en, 4'b0001);
        bus.slice_start = 1'b1;
        bus.clear_overrun = 1'b1;
        step();
        bus.slice_start = 1'b0;
        check("set_beats_clear", bus.overrun, 1);
        step();
        bus.clear_overrun = 1'b0;
        check("overrun_cleared", bus.overrun, 0);
        for (i = 0; i < 200 && bus.busy; i++) step();
        check("drain_busy", bus.busy, 0);
        step();
        // override mid-ON of row 1
        bus.slice_start = 1'b1;
        step();
        bus.slice_start = 1'b0;
        repeat (29) step();
        check("row1_on", bus.row_en, 4'b0010);
        bus.hps_override = 1'b1;
        bus.hps_row_en = 4'b1010;
        step();
        check("ovr_row_en", bus.row_en, 4'b1010);
        check("ovr_busy", bus.busy, 0);
        bus.slice_start = 1'b1;
        bus.hps_row_en = 4'b0101;
        step();
        bus.slice_start = 1'b0;
        check("ovr_no_overrun", bus.overrun, 0);
        check("ovr_ignore_start", {bus.busy, bus.lat_req}, 0);
        check("ovr_row_en2", bus.row_en, 4'b0101);
        seen = 1'b0;
        repeat (12) begin
            seen |= bus.slice_done;
            step();
        end
        check("ovr_no_done", seen, 0);
        bus.hps_override = 1'b0;
        bus.hps_row_en = '0;
        step();
        check("release_row_en", bus.row_en, 0);
        bus.on_cycles = 16'd2;
        bus.slice_start = 1'b1;
        step();
        bus.slice_start = 1'b0;
        check("restart_row0", {bus.row_idx, bus.lat_req, bus.busy}, 4'b0011);
        repeat (9) step();
        check("restart_on", bus.row_en, 4'b0001);
        bus.enable = 1'b0;
        step();
        check("abort_outs", {obs(), bus.overrun}, 0);
        bus.enable = 1'b1;
        step();
        // asynchronous reset while ON with overrun set
        bus.on_cycles = 16'd10;
        bus.slice_start = 1'b1;
        step();
        bus.slice_start = 1'b0;
        repeat (4) step();
        bus.slice_start = 1'b1;
        step();
        bus.slice_start = 1'b0;
        repeat (6) step();
        check("pre_rst", {bus.row_en, bus.overrun}, 5'b00011);
        #2;
        rst_in = 1'b1;
        #1;
        check("async_rst", {bus.row_en, bus.lat_req, bus.overrun, bus.busy}, 0);
        step();
        rst_in = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/row_mux_scheduler.md
# row_mux_scheduler

Sequences the multiplexed LED rows within one angular slice. For each row it requests a data latch from the LED band controller, blanks all rows for a dead time, then enables exactly one row for a programmable on-time. It sits between the synchronizer (slice start pulses) and the row-enable pins. It hands row control to the HPS whenever HPS override is asserted.

## Interface
Parameters:
- NB_MUX_ROWS, 4, number of multiplexed rows; must be ≥ 2.
- ON_WIDTH, 16, width of the on-time count.
- DEAD_CYCLES, 8, blanking cycles before each row is enabled; must be ≥ 1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_in  in  1  reset, asynchronous, active-high.
- enable  in  1  scheduler enable; low aborts any slice in progress.
- slice_start  in  1  one-cycle pulse from the synchronizer marking a new slice.
- on_cycles  in  ON_WIDTH  row on-time in clk cycles; sampled on an accepted slice_start.
- hps_override  in  1  HPS takes the row pins.
- hps_row_en  in  NB_MUX_ROWS  row pattern driven while hps_override is high.
- lat_ack  in  1  LED band controller has latched data for row_idx.
- clear_overrun  in  1  one-cycle pulse that clears overrun.
- row_en  out  NB_MUX_ROWS  registered row enables; at most one bit set when not overridden.
- row_idx  out  $clog2(NB_MUX_ROWS)  row currently being serviced.
- lat_req  out  1  latch request, held until acknowledged.
- busy  out  1  high in any state other than IDLE.
- slice_done  out  1  one-cycle pulse when the last row's on-time ends.
- overrun  out  1  sticky flag: slice_start arrived while busy.

## Operation
- States: IDLE, LATCH, DEAD, ON.
- IDLE:
  - On slice_start with enable=1 and hps_override=0: latch on_cycles into on_q, set row_idx=0, go to LATCH.
- LATCH:
  - lat_req=1 and row_en=0.
  - When lat_ack=1, go to DEAD and load the timer with DEAD_CYCLES.
- DEAD:
  - row_en=0; the timer counts down.
  - When the timer reaches its final cycle: if on_q=0, skip ON and apply the end-of-row rule below; otherwise go to ON and load the timer with on_q.
- ON:
  - row_en = one-hot(row_idx) for exactly on_q cycles.
  - At the end, apply the end-of-row rule.
- End-of-row rule:
  - If row_idx = NB_MUX_ROWS-1: pulse slice_done, go to IDLE, row_idx=0.
  - Otherwise: row_idx+1, go to LATCH.
- row_idx never wraps mid-slice; it only returns to 0 when a slice completes or aborts.
- Overrun:
  - slice_start while busy sets overrun, and that pulse is otherwise ignored.
  - If set and clear_overrun occur in the same cycle, set wins.
- Abort: enable=0 or hps_override=1 in any state sends the FSM to IDLE on the next edge.
  - Abort clears lat_req, sets row_idx=0, and gives no slice_done.
- Override output:
  - row_en = hps_row_en, registered, one-cycle latency, no one-hot check.
  - slice_start is ignored during override and does not set overrun.
- Reset: all outputs are 0 and the FSM is in IDLE; this takes effect immediately and asynchronously.

## Timing
- slice_start at cycle 0 → lat_req high from cycle 1.
- lat_ack sampled at cycle k while in LATCH (k ≥ 1) → DEAD occupies cycles k+1 … k+DEAD_CYCLES.
- row_en one-hot occupies the following on_q cycles.
- With lat_ack tied high, each row takes 1 + DEAD_CYCLES + on_q cycles.
  - Slice length is NB_MUX_ROWS × (1 + DEAD_CYCLES + on_q).
  - slice_done is asserted in the cycle after the last ON cycle, coincident with busy falling.
- A slice_start in the same cycle that slice_done is asserted is accepted: the FSM is already in IDLE.
- A change to on_cycles mid-slice has no effect until the next accepted slice_start.
- An abort drives row_en to 0 (or to hps_row_en under override) at the first edge after the abort condition.

## Structure
- Shared package led_ctrl_pkg holds:
  - the state enum row_sched_state_t {IDLE, LATCH, DEAD, ON};
  - the default parameter constants, shared with hps_io and the LED band controller.
- One sub-module, cycle_timer:
  - a loadable ON_WIDTH-bit down-counter with load, value and a last-cycle flag;
  - shared by the DEAD and ON states.
- The one-hot decoder and the override mux stay inline.

## Test plan
- Basic slice: NB_MUX_ROWS=4, DEAD_CYCLES=8, on_cycles=10, lat_ack tied high, slice_start at cycle 0.
  - Rows 0..3 are each one-hot for 10 cycles.
  - There are 8 blank cycles before each row.
  - slice_done occurs at cycle 77.
- Latch handshake: lat_ack delayed 5 cycles on row 2 → lat_req stays high for 5 cycles, row_en stays 0, and the rest of the timing shifts by 4.
- Zero on-time: on_cycles=0 → row_en is never set, and slice_done arrives after 4 × 9 = 36 cycles.
- Overrun: a second slice_start mid-slice → overrun=1 and the slice is not restarted.
  - clear_overrun together with a new mid-slice slice_start leaves overrun=1.
- Override mid-ON: hps_override=1 with hps_row_en=4'b1010 during row 1 → row_en=1010 on the next cycle, busy=0, no slice_done.
  - After release, the next slice_start starts again at row 0.
- Async reset while in ON → row_en=0, lat_req=0 and overrun=0 immediately, without waiting for a clock edge.
